// File: rtl/decode_stage.sv
// Instruction decode stage: register file, operand selection, RAW hazard
// detection against the instruction in execute, and stall/flush/bubble control.
module decode_stage #(
  parameter logic [4:0] NOP_OP = 5'b00011,
  parameter int         NREG   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr_if,
  input  logic        if_valid,
  output logic        id_ready,
  input  logic        ex_stall,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [2:0]  wb_addr,
  input  logic [7:0]  wb_data,
  output logic [4:0]  op_dec,
  output logic [7:0]  A,
  output logic [7:0]  B,
  output logic [2:0]  rd_dec,
  output logic        wr_en_dec,
  output logic        valid_dec
);

  logic [7:0] rf_q [NREG];

  logic [4:0] op_q, op_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [2:0] rdDec_q, rdDec_d;
  logic       wrEnDec_q, wrEnDec_d;
  logic       validDec_q, validDec_d;

  logic [4:0] opc;
  logic [2:0] rdIdx;
  logic [2:0] rsIdx;
  logic [7:0] imm8;
  logic       readsRd;
  logic       readsRs;
  logic       isImm;
  logic       wrEn;
  logic [7:0] opA;
  logic [7:0] opB;
  logic       hazard;

  assign opc   = instr_if[15:11];
  assign rdIdx = instr_if[10:8];
  assign rsIdx = instr_if[7:5];
  assign imm8  = instr_if[7:0];

  always_comb begin
    readsRd = 1'b0;
    case (opc)
      5'b00000, 5'b00001, 5'b00100, 5'b00101, 5'b00110,
      5'b01000, 5'b01001, 5'b01100, 5'b01101, 5'b01110,
      5'b10100, 5'b10101, 5'b10111,
      5'b11001, 5'b11010, 5'b11011: readsRd = 1'b1;
      default:                      readsRd = 1'b0;
    endcase
  end

  assign readsRs = (opc[4:3] == 2'b00) || (opc >= 5'b11001 && opc <= 5'b11011);
  assign isImm   = (opc[4:3] == 2'b01);

  always_comb begin
    wrEn = 1'b0;
    if (opc[4:3] == 2'b00)
      wrEn = (opc != 5'b00011);
    else if (opc[4:3] == 2'b01)
      wrEn = (opc != 5'b01011);
    else if (opc == 5'b10110)
      wrEn = 1'b1;
    else if (opc >= 5'b11001 && opc <= 5'b11011)
      wrEn = 1'b1;
  end

  // Register file reads see stored contents only; a same-cycle writeback
  // becomes visible the following cycle.
  assign opA = readsRd ? rf_q[rdIdx] : 8'h00;
  assign opB = readsRs ? rf_q[rsIdx] : (isImm ? imm8 : 8'h00);

  assign hazard = if_valid && validDec_q && wrEnDec_q &&
                  ((readsRd && rdIdx == rdDec_q) || (readsRs && rsIdx == rdDec_q));

  assign id_ready = rst_n & ~ex_stall & ~hazard;

  always_comb begin
    op_d       = NOP_OP;
    a_d        = 8'h00;
    b_d        = 8'h00;
    rdDec_d    = 3'd0;
    wrEnDec_d  = 1'b0;
    validDec_d = 1'b0;
    if (flush) begin
      op_d = NOP_OP;
    end else if (ex_stall) begin
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      rdDec_d    = rdDec_q;
      wrEnDec_d  = wrEnDec_q;
      validDec_d = validDec_q;
    end else if (hazard) begin
      op_d = NOP_OP;
    end else if (if_valid) begin
      op_d       = opc;
      a_d        = opA;
      b_d        = opB;
      rdDec_d    = rdIdx;
      wrEnDec_d  = wrEn;
      validDec_d = 1'b1;
    end
  end

  // Writeback proceeds through stall and flush; only reset blocks it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q       <= NOP_OP;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      rdDec_q    <= 3'd0;
      wrEnDec_q  <= 1'b0;
      validDec_q <= 1'b0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= 8'h00;
    end else begin
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rdDec_q    <= rdDec_d;
      wrEnDec_q  <= wrEnDec_d;
      validDec_q <= validDec_d;
      if (wb_en) rf_q[wb_addr] <= wb_data;
    end
  end

  assign op_dec    = op_q;
  assign A         = a_q;
  assign B         = b_q;
  assign rd_dec    = rdDec_q;
  assign wr_en_dec = wrEnDec_q;
  assign valid_dec = validDec_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: reference model feeds a scoreboard of
// expected output-register contents, plus directed checks of the key scenarios.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr_if;
  logic        if_valid;
  logic        id_ready;
  logic        ex_stall;
  logic        flush;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [7:0]  wb_data;
  logic [4:0]  op_dec;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [2:0]  rd_dec;
  logic        wr_en_dec;
  logic        valid_dec;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .instr_if(instr_if), .if_valid(if_valid),
    .id_ready(id_ready), .ex_stall(ex_stall), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .op_dec(op_dec), .A(A), .B(B), .rd_dec(rd_dec),
    .wr_en_dec(wr_en_dec), .valid_dec(valid_dec)
  );

  typedef struct packed {
    logic [4:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] rd;
    logic       wr;
    logic       valid;
  } outT;

  localparam outT BUBBLE = '{op: 5'b00011, a: 8'h00, b: 8'h00, rd: 3'd0, wr: 1'b0, valid: 1'b0};

  outT        sbQ[$];
  outT        mOut = BUBBLE;
  logic [7:0] mRf[8];
  int         assertCount = 0;
  int         failCount = 0;
  logic       lastIdReady;
  logic       lastExpReady;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic modelReadsRd(input logic [4:0] o);
    return o inside {5'd0, 5'd1, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9, 5'd12, 5'd13,
                     5'd14, 5'd20, 5'd21, 5'd23, 5'd25, 5'd26, 5'd27};
  endfunction

  function automatic logic modelReadsRs(input logic [4:0] o);
    return (o < 5'd8) || (o inside {5'd25, 5'd26, 5'd27});
  endfunction

  function automatic logic modelWr(input logic [4:0] o);
    if (o < 5'd8)   return o != 5'd3;
    if (o < 5'd16)  return o != 5'd11;
    return o inside {5'd22, 5'd25, 5'd26, 5'd27};
  endfunction

  function automatic outT modelDecode(input logic [15:0] ins);
    outT r;
    logic [4:0] o;
    o       = ins[15:11];
    r.op    = o;
    r.a     = modelReadsRd(o) ? mRf[ins[10:8]] : 8'h00;
    if (modelReadsRs(o))           r.b = mRf[ins[7:5]];
    else if (o >= 8 && o < 16)     r.b = ins[7:0];
    else                           r.b = 8'h00;
    r.rd    = ins[10:8];
    r.wr    = modelWr(o);
    r.valid = 1'b1;
    return r;
  endfunction

  // One clock cycle: drive inputs, predict id_ready and the next output
  // register, then compare after the edge.
  task automatic applyStimulus(input logic rst, input logic ifv, input logic [15:0] ins,
                               input logic stall, input logic fl, input logic we,
                               input logic [2:0] wa, input logic [7:0] wd);
    outT  expNext;
    outT  got;
    logic haz;
    rst_n = rst; if_valid = ifv; instr_if = ins; ex_stall = stall;
    flush = fl; wb_en = we; wb_addr = wa; wb_data = wd;
    haz = ifv && mOut.valid && mOut.wr &&
          ((modelReadsRd(ins[15:11]) && ins[10:8] == mOut.rd) ||
           (modelReadsRs(ins[15:11]) && ins[7:5] == mOut.rd));
    lastExpReady = rst && !stall && !haz;
    if (!rst)       expNext = BUBBLE;
    else if (fl)    expNext = BUBBLE;
    else if (stall) expNext = mOut;
    else if (haz)   expNext = BUBBLE;
    else if (ifv)   expNext = modelDecode(ins);
    else            expNext = BUBBLE;
    sbQ.push_back(expNext);
    @(negedge clk);
    lastIdReady = id_ready;
    checkOutput("id_ready", id_ready, lastExpReady);
    @(posedge clk);
    mOut = expNext;
    if (!rst) for (int i = 0; i < 8; i++) mRf[i] = 8'h00;
    else if (we) mRf[wa] = wd;
    #1;
    got = sbQ.pop_front();
    checkOutput("op_dec", op_dec, got.op);
    checkOutput("A", A, got.a);
    checkOutput("B", B, got.b);
    checkOutput("rd_dec", rd_dec, got.rd);
    checkOutput("wr_en_dec", wr_en_dec, got.wr);
    checkOutput("valid_dec", valid_dec, got.valid);
  endtask

  task automatic sendInstr(input logic [15:0] ins);
    logic accepted;
    accepted = 1'b0;
    for (int k = 0; k < 8 && !accepted; k++) begin
      applyStimulus(1'b1, 1'b1, ins, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
      accepted = lastExpReady;
    end
    checkOutput("send_timeout", accepted, 1'b1);
  endtask

  task automatic idle(input logic we, input logic [2:0] wa, input logic [7:0] wd);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, we, wa, wd);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] held;
    logic        hv;
    for (int i = 0; i < 8; i++) mRf[i] = 8'h00;

    // Reset with a valid instruction presented
    applyStimulus(1'b0, 1'b1, 16'b01000_001_00000011, 1'b0, 1'b0, 1'b1, 3'd2, 8'hAA);
    applyStimulus(1'b0, 1'b1, 16'b01000_001_00000011, 1'b0, 1'b0, 1'b1, 3'd2, 8'hAA);
    checkOutput("rst_op", op_dec, 5'b00011);
    checkOutput("rst_valid", valid_dec, 1'b0);
    checkOutput("rst_ready", lastIdReady, 1'b0);

    for (int i = 0; i < 8; i++) begin
      sendInstr({5'b11001, 3'(i), 3'(7 - i), 5'b00000});
      checkOutput("rst_regA", A, 8'h00);
      checkOutput("rst_regB", B, 8'h00);
    end

    // Immediate instruction
    idle(1'b1, 3'd1, 8'h05);
    sendInstr(16'b01000_001_00000011);
    checkOutput("imm_op", op_dec, 5'b01000);
    checkOutput("imm_A", A, 8'h05);
    checkOutput("imm_B", B, 8'h03);
    checkOutput("imm_rd", rd_dec, 3'd1);
    checkOutput("imm_wr", wr_en_dec, 1'b1);
    checkOutput("imm_valid", valid_dec, 1'b1);

    // RAW hazard: exactly one bubble
    idle(1'b1, 3'd2, 8'h10);
    idle(1'b1, 3'd3, 8'h01);
    idle(1'b1, 3'd4, 8'h0F);
    sendInstr(16'b00000_010_011_00000);
    applyStimulus(1'b1, 1'b1, 16'b00100_100_010_00000, 1'b0, 1'b0, 1'b1, 3'd2, 8'h11);
    checkOutput("raw_ready", lastIdReady, 1'b0);
    checkOutput("raw_bubble", valid_dec, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'b00100_100_010_00000, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    checkOutput("raw_ready2", lastIdReady, 1'b1);
    checkOutput("raw_op", op_dec, 5'b00100);
    checkOutput("raw_A", A, 8'h0F);
    checkOutput("raw_B", B, 8'h11);

    // Stall holds outputs for three cycles
    sendInstr(16'b01001_011_00000111);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 16'b00101_101_001_00000, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
      checkOutput("stall_ready", lastIdReady, 1'b0);
      checkOutput("stall_op", op_dec, 5'b01001);
      checkOutput("stall_A", A, 8'h01);
    end
    applyStimulus(1'b1, 1'b1, 16'b00101_101_001_00000, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    checkOutput("unstall_op", op_dec, 5'b00101);
    checkOutput("unstall_B", B, 8'h05);

    // Flush together with stall; writeback still lands
    applyStimulus(1'b1, 1'b1, 16'b00110_000_000_00000, 1'b1, 1'b1, 1'b1, 3'd5, 8'h5A);
    checkOutput("flush_op", op_dec, 5'b00011);
    checkOutput("flush_valid", valid_dec, 1'b0);
    idle(1'b0, 3'd0, 8'h00);
    checkOutput("flush_dropped", valid_dec, 1'b0);
    sendInstr(16'b00001_101_101_00000);
    checkOutput("flush_wbA", A, 8'h5A);
    checkOutput("flush_wbB", B, 8'h5A);

    // Reset one cycle after a hazard is detected
    sendInstr(16'b01000_110_00000001);
    applyStimulus(1'b1, 1'b1, 16'b00000_000_110_00000, 1'b0, 1'b0, 1'b1, 3'd6, 8'h77);
    checkOutput("rsthz_ready", lastIdReady, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'b00000_000_110_00000, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    checkOutput("rsthz_op", op_dec, 5'b00011);
    applyStimulus(1'b1, 1'b1, 16'b00000_000_110_00000, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    checkOutput("rsthz_ready2", lastIdReady, 1'b1);
    checkOutput("rsthz_valid", valid_dec, 1'b1);
    checkOutput("rsthz_B", B, 8'h00);

    // Random traffic; fetch holds the instruction until accepted
    held = 16'($urandom);
    hv = 1'b1;
    for (int c = 0; c < 300; c++) begin
      applyStimulus($urandom_range(0, 49) != 0, hv, held,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                    1'($urandom), 3'($urandom), 8'($urandom));
      if (!hv || lastExpReady) begin
        held = 16'($urandom);
        hv = $urandom_range(0, 3) != 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
